// File: rtl/srl_fifo_if.sv
// Valid/ready stream bundle for srl_fifo: write side (s_*) and read side (m_*).
// The FIFO takes the slave view; the producer/consumer environment takes the master view.
interface srl_fifo_if #(
  parameter int NBITS = 8
);
  logic [NBITS-1:0] s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic [NBITS-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid
  );

  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid
  );
endinterface

// File: rtl/srl_fifo.sv
// First-word-fall-through FIFO built from an addressable shift register (srlvec)
// plus a registered output stage; capacity is DEPTH+1 words.
module srlvec #(
  parameter int    NBITS     = 8,
  parameter string USE_SRL16 = "TRUE",
  localparam int   DEPTH     = (USE_SRL16 == "TRUE") ? 16 : 32,
  localparam int   ADDR_BITS = (USE_SRL16 == "TRUE") ? 4 : 5
) (
  input  logic                 clk,
  input  logic                 ce,
  input  logic [ADDR_BITS-1:0] a,
  input  logic [NBITS-1:0]     din,
  output logic [NBITS-1:0]     dout
);
  logic [NBITS-1:0] mem [DEPTH];

  // NOTE: storage has no reset on purpose; an SRL primitive cannot be reset and
  // the control stage never reads an entry that was not written since reset.
  always_ff @(posedge clk) begin
    if (ce) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[a];
endmodule

module srl_fifo #(
  parameter int    NBITS     = 8,
  parameter string USE_SRL16 = "TRUE",
  localparam int   DEPTH     = (USE_SRL16 == "TRUE") ? 16 : 32,
  localparam int   ADDR_BITS = (USE_SRL16 == "TRUE") ? 4 : 5
) (
  input  logic               clk,
  input  logic               rst_n,
  srl_fifo_if.slave          bus,
  output logic [ADDR_BITS:0] count
);
  localparam logic [ADDR_BITS:0] ONE     = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);

  logic [ADDR_BITS:0]   sc, sc_next, sc_m1;
  logic                 out_v, rdy_q;
  logic [NBITS-1:0]     out_d, srl_dout;
  logic [ADDR_BITS-1:0] srl_a;
  logic                 wr, ld, pop;

  assign wr    = bus.s_tvalid && rdy_q;
  assign pop   = out_v && bus.m_tready;
  assign ld    = (sc != '0) && (!out_v || bus.m_tready);
  assign sc_m1 = sc - ONE;
  // Oldest word sits at sc-1; a shift on the same edge as a load moves the next
  // oldest into that slot, so the address never needs a look-ahead.
  assign srl_a = (sc != '0) ? sc_m1[ADDR_BITS-1:0] : '0;

  srlvec #(
    .NBITS    (NBITS),
    .USE_SRL16(USE_SRL16)
  ) u_srl (
    .clk (clk),
    .ce  (wr),
    .a   (srl_a),
    .din (bus.s_tdata),
    .dout(srl_dout)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sc_next = sc;
    unique case ({wr, ld})
      2'b10:   sc_next = sc + ONE;
      2'b01:   sc_next = sc_m1;
      default: sc_next = sc;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc    <= '0;
      out_v <= 1'b0;
      out_d <= '0;
      rdy_q <= 1'b0;
    end else begin
      sc    <= sc_next;
      rdy_q <= (sc_next < DEPTH_C);
      if (ld) begin
        out_d <= srl_dout;
        out_v <= 1'b1;
      end else if (pop) begin
        out_v <= 1'b0;
      end
    end
  end

  assign bus.s_tready = rdy_q;
  assign bus.m_tvalid = out_v;
  assign bus.m_tdata  = out_d;
  assign count        = sc + {{ADDR_BITS{1'b0}}, out_v};
endmodule

// File: tb/tb_srl_fifo.sv
// Scoreboard bench for srl_fifo: directed fill/drain/stream/reset cases on both
// depths plus a randomized run, all checked against a queue model by monitors.
module tb_srl_fifo;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  srl_fifo_if #(.NBITS(8)) b16();
  srl_fifo_if #(.NBITS(8)) b32();
  logic [4:0] count16;
  logic [5:0] count32;

  srl_fifo #(.NBITS(8), .USE_SRL16("TRUE"))  dut16 (.clk(clk), .rst_n(rst_n), .bus(b16), .count(count16));
  srl_fifo #(.NBITS(8), .USE_SRL16("FALSE")) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32), .count(count32));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of accepted words, capacity 17 / 33.
  logic [7:0] q16[$];
  logic [7:0] q32[$];
  logic       hold16 = 1'b0, hold32 = 1'b0;
  logic [7:0] hd16, hd32;

  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete();
      hold16 = 1'b0;
    end else begin
      check("count16_model", 32'(count16), q16.size());
      check("cap16", 32'(q16.size() <= 17), 1);
      check("sc16_max", 32'(dut16.sc <= 5'd16), 1);
      if (dut16.wr) check("ce16_when_full", 32'(dut16.sc != 5'd16), 1);
      if (q16.size() == 17) check("ready16_full", b16.s_tready, 0);
      if (hold16) begin
        check("hold16_valid", b16.m_tvalid, 1);
        check("hold16_data", b16.m_tdata, hd16);
      end
      if (b16.m_tvalid) begin
        if (q16.size() == 0) check("valid16_empty", b16.m_tvalid, 0);
        else check("head16_data", b16.m_tdata, q16[0]);
      end
      hold16 = b16.m_tvalid && !b16.m_tready;
      hd16   = b16.m_tdata;
      if (b16.s_tvalid && b16.s_tready) q16.push_back(b16.s_tdata);
      if (b16.m_tvalid && b16.m_tready && q16.size() > 0) void'(q16.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q32.delete();
      hold32 = 1'b0;
    end else begin
      check("count32_model", 32'(count32), q32.size());
      check("cap32", 32'(q32.size() <= 33), 1);
      if (q32.size() == 33) check("ready32_full", b32.s_tready, 0);
      if (hold32) check("hold32_data", b32.m_tdata, hd32);
      if (b32.m_tvalid) begin
        if (q32.size() == 0) check("valid32_empty", b32.m_tvalid, 0);
        else check("head32_data", b32.m_tdata, q32[0]);
      end
      hold32 = b32.m_tvalid && !b32.m_tready;
      hd32   = b32.m_tdata;
      if (b32.s_tvalid && b32.s_tready) q32.push_back(b32.s_tdata);
      if (b32.m_tvalid && b32.m_tready && q32.size() > 0) void'(q32.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain16();
    b16.s_tvalid = 1'b0;
    b16.m_tready = 1'b1;
    for (int i = 0; i < 80 && count16 != 0; i++) tick();
    tick();
    check("drain16_count", 32'(count16), 0);
    check("drain16_valid", b16.m_tvalid, 0);
    b16.m_tready = 1'b0;
  endtask

  task automatic fill16(input int n, input logic [7:0] base);
    b16.m_tready = 1'b0;
    for (int i = 0; i < n; i++) begin
      b16.s_tvalid = 1'b1;
      b16.s_tdata  = base + 8'(i);
      tick();
    end
    b16.s_tvalid = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    b16.s_tdata = '0; b16.s_tvalid = 1'b0; b16.m_tready = 1'b0;
    b32.s_tdata = '0; b32.s_tvalid = 1'b0; b32.m_tready = 1'b0;
    #1;
    check("rst_valid", b16.m_tvalid, 0);
    check("rst_ready", b16.s_tready, 0);
    check("rst_count", 32'(count16), 0);
    #11 rst_n = 1'b1;

    // Single word latency: accepted at edge N, visible after N+1.
    tick();
    check("ready_after_rst", b16.s_tready, 1);
    tick();
    b16.s_tvalid = 1'b1;
    b16.s_tdata  = 8'hA5;
    tick();
    b16.s_tvalid = 1'b0;
    check("lat_not_yet", b16.m_tvalid, 0);
    check("lat_count_n", 32'(count16), 1);
    tick();
    check("lat_valid", b16.m_tvalid, 1);
    check("lat_data", b16.m_tdata, 8'hA5);
    repeat (3) tick();
    check("lat_count_hold", 32'(count16), 1);
    drain16();

    // Fill with 0x00..0x20: exactly 17 accepted, then one-per-cycle drain.
    b16.m_tready = 1'b0;
    for (int i = 0; i <= 32; i++) begin
      b16.s_tvalid = 1'b1;
      b16.s_tdata  = 8'(i);
      tick();
    end
    b16.s_tvalid = 1'b0;
    check("full_count", 32'(count16), 17);
    check("full_ready", b16.s_tready, 0);
    check("full_head", b16.m_tdata, 8'h00);
    b16.m_tready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      check("drain_rate", 32'(count16), 32'(16 - k));
    end
    check("drain_done_valid", b16.m_tvalid, 0);
    b16.m_tready = 1'b0;

    // Full FIFO, then stream both sides continuously.
    fill16(17, 8'h40);
    check("refill_count", 32'(count16), 17);
    b16.m_tready = 1'b1;
    b16.s_tvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b16.s_tdata = 8'h80 + 8'(i);
      tick();
      check("stream_count", 32'(count16 >= 5'd16 && count16 <= 5'd17), 1);
      check("stream_ready", b16.s_tready, 1);
      check("stream_valid", b16.m_tvalid, 1);
    end
    drain16();

    // Random traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      b16.s_tvalid = 1'($urandom_range(0, 1));
      b16.s_tdata  = 8'($urandom);
      b16.m_tready = 1'($urandom_range(0, 1));
      tick();
    end
    drain16();

    // Deep variant: 33 entries.
    b32.m_tready = 1'b0;
    for (int i = 1; i <= 36; i++) begin
      b32.s_tvalid = 1'b1;
      b32.s_tdata  = 8'(i);
      tick();
    end
    b32.s_tvalid = 1'b0;
    check("full32_count", 32'(count32), 33);
    check("full32_ready", b32.s_tready, 0);
    check("full32_head", b32.m_tdata, 8'h01);
    b32.m_tready = 1'b1;
    for (int i = 0; i < 80 && count32 != 0; i++) tick();
    tick();
    check("drain32_count", 32'(count32), 0);
    check("drain32_valid", b32.m_tvalid, 0);
    b32.m_tready = 1'b0;

    // Asynchronous reset mid-stream at count 9.
    fill16(9, 8'h10);
    check("pre_rst_count", 32'(count16), 9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", b16.m_tvalid, 0);
    check("arst_ready", b16.s_tready, 0);
    check("arst_count", 32'(count16), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("rst2_ready", b16.s_tready, 1);
    b16.s_tvalid = 1'b1;
    b16.s_tdata  = 8'h3C;
    tick();
    b16.s_tvalid = 1'b0;
    for (int i = 0; i < 10 && !b16.m_tvalid; i++) tick();
    check("post_rst_valid", b16.m_tvalid, 1);
    check("post_rst_data", b16.m_tdata, 8'h3C);
    check("post_rst_count", 32'(count16), 1);
    drain16();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/srl_fifo.md
Name: srl_fifo

Overview:
- Small first-word-fall-through (FWFT) FIFO with valid/ready handshakes on both sides.
- Data storage is an internal srlvec instance; this block generates the srlvec ce, a and din signals and registers srlvec dout into an output stage.
- It is the control stage that drives srlvec. Used for short elastic buffering (clock-crossing-free skid/rate smoothing) in datapaths where LUT-SRL density matters more than BRAM.

Parameters:
- NBITS, 8, data word width.
- USE_SRL16, "TRUE", passed to srlvec. "TRUE" gives DEPTH=16 and ADDR_BITS=4; anything else gives DEPTH=32 and ADDR_BITS=5.
- DEPTH (localparam), 16 or 32, SRL storage entries. Total capacity is DEPTH+1 (the SRL plus the output register).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_tdata  in  NBITS  write data.
- s_tvalid  in  1  write request.
- s_tready  out  1  write accept; a write occurs on s_tvalid&&s_tready.
- m_tdata  out  NBITS  head-of-FIFO data; valid while m_tvalid=1.
- m_tvalid  out  1  output register holds a word.
- m_tready  in  1  consumer accept; a pop occurs on m_tvalid&&m_tready.
- count  out  ADDR_BITS+1  total occupancy = sc + m_tvalid, range 0..DEPTH+1.

Behaviour:
- Internal state:
  - sc: SRL occupancy, 0..DEPTH, ADDR_BITS+1 bits.
  - out_v: drives m_tvalid.
  - out_d: drives m_tdata.
  - rdy_q: drives s_tready.
- Reset (rst_n low, asynchronous): sc=0, out_v=0, out_d=0, rdy_q=0, count=0.
  - SRL contents are not reset and are don't-care.
  - Reset mid-operation discards all words; no m_tvalid pulse follows reset.
- srlvec hookup:
  - din=s_tdata.
  - ce=wr, where wr = s_tvalid && rdy_q.
  - a = sc-1 truncated to ADDR_BITS when sc>0; a=0 when sc=0 (don't-care).
  - The SRL read is combinational; the oldest word is at address sc-1.
- Load: ld = (sc>0) && (!out_v || m_tready).
  - On ld, out_d <= srlvec dout and out_v <= 1.
  - If pop && !ld, then out_v <= 0 and out_d holds its old value.
- sc update:
  - sc <= sc + wr - ld.
  - With wr&&ld in the same cycle, sc is unchanged. The shift moves the next-oldest word to address sc-1, which is correct by construction.
- rdy_q <= (sc_next < DEPTH), a registered value.
  - The first clock after reset release sets rdy_q=1.
  - s_tready has no combinational path from any input.
- Latency:
  - A word accepted at edge N into an empty FIFO gives sc=1 after N and m_tvalid=1 after edge N+1, i.e. 2 cycles write-to-valid.
  - Throughput is 1 word/cycle sustained when both sides stream.
- Full:
  - sc=DEPTH forces s_tready=0 on the next cycle.
  - With a pop in the full cycle, ld frees a slot: sc_next=DEPTH-1 and s_tready=1 after the edge.
  - s_tvalid while s_tready=0 is ignored; data is not captured.
- Empty:
  - m_tvalid=0 with m_tready=1 is harmless; no state changes.
  - Simultaneous write and empty-read cannot underflow because ld requires sc>0.
- count is combinational from registers only: sc + out_v.
- Assertions (bench):
  - sc never exceeds DEPTH.
  - ce never fires when sc=DEPTH.
  - m_tdata is stable while m_tvalid && !m_tready.

Test Plan:
- Reset release, then write 0xA5 at cycle 3 with m_tready=0 -> s_tready=1 from cycle 1; m_tvalid=1 with m_tdata=0xA5 at cycle 5; count=1 and stays.
- USE_SRL16="TRUE", m_tready=0, write 0x00..0x20 continuously -> 17 words accepted (0x00..0x10), s_tready=0 thereafter, count=17. Then m_tready=1 -> outputs 0x00..0x10 in order, one per cycle, then m_tvalid=0 and count=0.
- Full FIFO (count=17), m_tready=1 and s_tvalid=1 continuously -> after a one-cycle ready bubble, sustained 1-in/1-out, count constant at 16 or 17, data strictly in order with no duplicates or drops.
- Random s_tvalid/m_tready at 50% each for 2000 cycles against a reference queue model -> zero mismatches; count matches the model every cycle; m_tdata stable under backpressure.
- USE_SRL16="FALSE", fill with 0x01..0x21 -> count=33 and s_tready=0; drain returns 0x01..0x21 in order.
- Assert rst_n low mid-stream at count=9 -> m_tvalid=0, s_tready=0 and count=0 immediately (asynchronous). After release, the first new word 0x3C emerges and no stale data appears.
